// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: EX-stage <-> HI/LO unit bundle.
// Latency: n/a (wires only).
// Backpressure: stall_o is the only backpressure; the EX stage holds its instruction while it is high.
//
// Signals:
//   valid_i       EX-stage instruction valid
//   alucontrol_i  5-bit ALU control code
//   a_i / b_i     rs / rt operands
//   flush_i       exception flush, cancels the EX instruction
//   stall_o       pipeline stall request
//   busy_o        divider sequencer not idle
//   hi_o / lo_o   registered HI / LO
interface muldiv_ctrl_if;
  logic        valid_i;
  logic [4:0]  alucontrol_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  // master: the EX stage that issues operations and reads HI/LO
  modport master (
    output valid_i, alucontrol_i, a_i, b_i, flush_i,
    input  stall_o, busy_o, hi_o, lo_o
  );

  // slave: the HI/LO owner
  modport slave (
    input  valid_i, alucontrol_i, a_i, b_i, flush_i,
    output stall_o, busy_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO owner and sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO in EX.
// Latency: MULT/MULTU/MTHI/MTLO write HI/LO at the end of the issue cycle; DIV/DIVU
//   stall 33 cycles (1 with fast divide-by-zero) and write HI/LO in the following DONE cycle.
// Backpressure: stall_o freezes the pipeline during a divide; flush_i aborts it.
//
// Ports:
//   clk   clock, rising edge
//   rst   synchronous reset, active-low
//   bus   muldiv_ctrl_if.slave (valid_i, alucontrol_i, a_i, b_i, flush_i,
//         stall_o, busy_o, hi_o, lo_o)
// Optional build macro: MDU_DIV_ZERO_FAST_EN -- a zero divisor skips the
//   iterations and goes straight from IDLE to DONE.
module muldiv_ctrl #(
  parameter int DIV_ITERS = 32
) (
  input logic          clk,
  input logic          rst,
  muldiv_ctrl_if.slave bus
);

  // ALU control codes for the operations this unit owns
  localparam logic [4:0] MULT_CONTROL  = 5'b10000;
  localparam logic [4:0] MULTU_CONTROL = 5'b10001;
  localparam logic [4:0] DIV_CONTROL   = 5'b10010;
  localparam logic [4:0] DIVU_CONTROL  = 5'b10011;
  localparam logic [4:0] MTHI_CONTROL  = 5'b10100;
  localparam logic [4:0] MTLO_CONTROL  = 5'b10101;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = $clog2(DIV_ITERS + 1);

`ifdef MDU_DIV_ZERO_FAST_EN
  localparam logic FAST_DZ = 1'b1;
`else
  localparam logic FAST_DZ = 1'b0;
`endif

  logic [1:0]    r_state;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [31:0]   r_rem;     // partial remainder
  logic [31:0]   r_quo;     // dividend shifting out / quotient shifting in
  logic [31:0]   r_dvsr;    // divisor magnitude
  logic [31:0]   r_a_raw;   // original dividend, HI result on divide by zero
  logic          r_neg_q;
  logic          r_neg_r;
  logic          r_dz;
  logic [CW-1:0] r_cnt;

  logic          w_accept;
  logic          w_is_div;
  logic          w_div_go;
  logic          w_signed;
  logic          w_a_neg;
  logic          w_b_neg;
  logic [31:0]   w_a_abs;
  logic [31:0]   w_b_abs;
  logic          w_b_zero;
  logic [63:0]   w_prod_s;
  logic [63:0]   w_prod_u;
  logic [32:0]   w_shift;
  logic [32:0]   w_diff;
  logic          w_fits;
  logic [31:0]   w_rem_nxt;
  logic [31:0]   w_quo_nxt;
  logic [31:0]   w_q_fix;
  logic [31:0]   w_r_fix;
  logic [31:0]   w_res_hi;
  logic [31:0]   w_res_lo;

  // Only an IDLE unit takes new work; DONE ignores the still-present divide.
  assign w_accept = bus.valid_i && !bus.flush_i && (r_state == S_IDLE);
  assign w_is_div = (bus.alucontrol_i == DIV_CONTROL) || (bus.alucontrol_i == DIVU_CONTROL);
  assign w_div_go = w_accept && w_is_div;
  assign w_signed = (bus.alucontrol_i == DIV_CONTROL);

  assign w_a_neg  = w_signed && bus.a_i[31];
  assign w_b_neg  = w_signed && bus.b_i[31];
  assign w_a_abs  = w_a_neg ? (~bus.a_i + 32'd1) : bus.a_i;
  assign w_b_abs  = w_b_neg ? (~bus.b_i + 32'd1) : bus.b_i;
  assign w_b_zero = (bus.b_i == 32'd0);

  assign w_prod_s = $signed({{32{bus.a_i[31]}}, bus.a_i}) * $signed({{32{bus.b_i[31]}}, bus.b_i});
  assign w_prod_u = {32'd0, bus.a_i} * {32'd0, bus.b_i};

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The remainder stays below the divisor, so both outcomes fit in 32 bits.
  assign w_shift   = {r_rem, r_quo[31]};
  assign w_diff    = w_shift - {1'b0, r_dvsr};
  assign w_fits    = !w_diff[32];
  assign w_rem_nxt = w_fits ? w_diff[31:0] : w_shift[31:0];
  assign w_quo_nxt = {r_quo[30:0], w_fits};

  // Sign correction: quotient negative iff operand signs differ, remainder follows the dividend.
  // |0x80000000| = 0x80000000 and its negation wraps back, giving the INT_MIN / -1 result.
  assign w_q_fix  = r_neg_q ? (~r_quo + 32'd1) : r_quo;
  assign w_r_fix  = r_neg_r ? (~r_rem + 32'd1) : r_rem;
  assign w_res_hi = r_dz ? r_a_raw : w_r_fix;
  assign w_res_lo = r_dz ? 32'hFFFF_FFFF : w_q_fix;

  // Stall drops in the flush cycle and in DONE so the pipeline can advance.
  assign bus.stall_o = w_div_go || ((r_state == S_DIV) && !bus.flush_i);
  assign bus.busy_o  = (r_state != S_IDLE);
  assign bus.hi_o    = r_hi;
  assign bus.lo_o    = r_lo;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_rem   <= 32'd0;
      r_quo   <= 32'd0;
      r_dvsr  <= 32'd0;
      r_a_raw <= 32'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (bus.alucontrol_i)
              MULT_CONTROL:  {r_hi, r_lo} <= w_prod_s;
              MULTU_CONTROL: {r_hi, r_lo} <= w_prod_u;
              MTHI_CONTROL:  r_hi <= bus.a_i;
              MTLO_CONTROL:  r_lo <= bus.a_i;
              DIV_CONTROL, DIVU_CONTROL: begin
                r_rem   <= 32'd0;
                r_quo   <= w_a_abs;
                r_dvsr  <= w_b_abs;
                r_a_raw <= bus.a_i;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
                r_dz    <= w_b_zero;
                r_cnt   <= '0;
                r_state <= (FAST_DZ && w_b_zero) ? S_DONE : S_DIV;
              end
              default: ;
            endcase
          end
        end
        S_DIV: begin
          if (bus.flush_i) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(DIV_ITERS - 1)) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (!bus.flush_i) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed bench for muldiv_ctrl with a cycle-level reference model.
// Latency: n/a.
// Backpressure: holds the divide instruction on the bus while stall_o is high.
module tb_muldiv_ctrl;

  localparam logic [4:0] MULT_C  = 5'b10000;
  localparam logic [4:0] MULTU_C = 5'b10001;
  localparam logic [4:0] DIV_C   = 5'b10010;
  localparam logic [4:0] DIVU_C  = 5'b10011;
  localparam logic [4:0] MTHI_C  = 5'b10100;
  localparam logic [4:0] MTLO_C  = 5'b10101;

`ifdef MDU_DIV_ZERO_FAST_EN
  localparam int DZ_STALLS = 1;
`else
  localparam int DZ_STALLS = 33;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_ctrl_if bus ();

  muldiv_ctrl #(.DIV_ITERS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_left counts the cycles until a pending divide result lands:
  // 0 = idle, >1 = still stalling, 1 = the result lands at the end of this cycle.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_left = 0;

  function automatic void div_ref(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
  endfunction

  always @(posedge clk) begin
    longint          ps;
    longint unsigned ua, ub;
    if (!rst) begin
      m_hi = 32'd0; m_lo = 32'd0; m_left = 0;
    end else if (m_left > 0) begin
      if (bus.flush_i) m_left = 0;
      else if (m_left == 1) begin
        m_hi = m_phi; m_lo = m_plo; m_left = 0;
      end else m_left = m_left - 1;
    end else if (bus.valid_i && !bus.flush_i) begin
      case (bus.alucontrol_i)
        MULT_C: begin
          ps = longint'($signed(bus.a_i)) * longint'($signed(bus.b_i));
          m_hi = ps[63:32]; m_lo = ps[31:0];
        end
        MULTU_C: begin
          ua = bus.a_i; ub = bus.b_i;
          ps = longint'(ua * ub);
          m_hi = ps[63:32]; m_lo = ps[31:0];
        end
        MTHI_C: m_hi = bus.a_i;
        MTLO_C: m_lo = bus.a_i;
        DIV_C, DIVU_C: begin
          div_ref(bus.alucontrol_i == DIV_C, bus.a_i, bus.b_i, m_plo, m_phi);
          m_left = (bus.b_i == 32'd0) ? DZ_STALLS : 33;
        end
        default: ;
      endcase
    end
  end

  // Single compare point: every negedge once out of the first reset.
  always @(negedge clk) begin
    logic exp_stall;
    if (chk_en) begin
      exp_stall = ((m_left == 0) && bus.valid_i && !bus.flush_i &&
                   (bus.alucontrol_i == DIV_C || bus.alucontrol_i == DIVU_C)) ||
                  ((m_left > 1) && !bus.flush_i);
      check("model_hi", bus.hi_o, m_hi);
      check("model_lo", bus.lo_o, m_lo);
      check("model_busy", {31'd0, bus.busy_o}, {31'd0, m_left > 0});
      check("model_stall", {31'd0, bus.stall_o}, {31'd0, exp_stall});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
    bus.valid_i = 1'b1; bus.alucontrol_i = code; bus.a_i = a; bus.b_i = b;
    @(negedge clk);
    check("no_stall_single", {31'd0, bus.stall_o}, 32'd0);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
  endtask

  // Holds the divide on the bus while stalled, then through the DONE cycle.
  task automatic run_div(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                         output int stalls);
    bit done = 1'b0;
    stalls = 0;
    bus.valid_i = 1'b1; bus.alucontrol_i = code; bus.a_i = a; bus.b_i = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.stall_o) begin
        stalls++;
        @(posedge clk); #1;
      end else begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL div_timeout: stall still %b after 100 cycles, expected 0", bus.stall_o);
    end
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    @(negedge clk);
    check("no_reaccept_busy", {31'd0, bus.busy_o}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    int st;
    rst = 1'b0;
    bus.valid_i = 1'b0; bus.alucontrol_i = 5'd0; bus.a_i = 32'd0; bus.b_i = 32'd0; bus.flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("reset_hi", bus.hi_o, 32'd0);
    check("reset_lo", bus.lo_o, 32'd0);
    check("reset_busy", {31'd0, bus.busy_o}, 32'd0);
    check("reset_stall", {31'd0, bus.stall_o}, 32'd0);
    @(posedge clk); #1;

    // 1: signed and unsigned multiply
    issue(MULT_C, 32'hFFFF_FFFD, 32'd7);
    check("mult_hi", bus.hi_o, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo_o, 32'hFFFF_FFEB);
    issue(MULTU_C, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_hi", bus.hi_o, 32'hFFFF_FFFE);
    check("multu_lo", bus.lo_o, 32'h0000_0001);

    // 2: unsigned divide, full stall length
    run_div(DIVU_C, 32'd100, 32'd7, st);
    check("divu_stalls", st, 32'd33);
    check("divu_hi", bus.hi_o, 32'd2);
    check("divu_lo", bus.lo_o, 32'h0000_000E);

    // 3: signed divides including INT_MIN / -1
    run_div(DIV_C, 32'hFFFF_FFF9, 32'd2, st);
    check("div_neg_lo", bus.lo_o, 32'hFFFF_FFFD);
    check("div_neg_hi", bus.hi_o, 32'hFFFF_FFFF);
    run_div(DIV_C, 32'h8000_0000, 32'hFFFF_FFFF, st);
    check("div_ovf_lo", bus.lo_o, 32'h8000_0000);
    check("div_ovf_hi", bus.hi_o, 32'd0);
    run_div(DIV_C, 32'd7, 32'hFFFF_FFFE, st);
    check("div_negb_lo", bus.lo_o, 32'hFFFF_FFFD);
    check("div_negb_hi", bus.hi_o, 32'd1);

    // 4: divide by zero, both signedness
    run_div(DIV_C, 32'd5, 32'd0, st);
    check("dz_stalls", st, DZ_STALLS);
    check("dz_hi", bus.hi_o, 32'd5);
    check("dz_lo", bus.lo_o, 32'hFFFF_FFFF);
    run_div(DIV_C, 32'hFFFF_FFF8, 32'd0, st);
    check("dz_neg_hi", bus.hi_o, 32'hFFFF_FFF8);
    check("dz_neg_lo", bus.lo_o, 32'hFFFF_FFFF);
    run_div(DIVU_C, 32'hFFFF_FFF0, 32'd0, st);
    check("dzu_hi", bus.hi_o, 32'hFFFF_FFF0);
    check("dzu_lo", bus.lo_o, 32'hFFFF_FFFF);

    // unknown code and flushed op in IDLE write nothing
    issue(5'b00010, 32'h1111_1111, 32'h2222_2222);
    check("unknown_hi", bus.hi_o, 32'hFFFF_FFF0);
    bus.flush_i = 1'b1;
    issue(MTLO_C, 32'h7777_7777, 32'd0);
    bus.flush_i = 1'b0;
    check("flush_idle_lo", bus.lo_o, 32'hFFFF_FFFF);

    // 5: MTHI then a divide flushed at DIV step 10
    issue(MTHI_C, 32'h0000_1234, 32'd0);
    check("mthi_hi", bus.hi_o, 32'h0000_1234);
    bus.valid_i = 1'b1; bus.alucontrol_i = DIVU_C; bus.a_i = 32'd9; bus.b_i = 32'd2;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1 bus.flush_i = 1'b1;
    @(negedge clk);
    check("flush_stall", {31'd0, bus.stall_o}, 32'd0);
    check("flush_busy_before", {31'd0, bus.busy_o}, 32'd1);
    @(posedge clk); #1;
    bus.flush_i = 1'b0; bus.valid_i = 1'b0;
    @(negedge clk);
    check("flush_busy_after", {31'd0, bus.busy_o}, 32'd0);
    check("flush_hi_kept", bus.hi_o, 32'h0000_1234);
    check("flush_lo_kept", bus.lo_o, 32'hFFFF_FFFF);
    @(posedge clk); #1;

    // 6: reset mid-divide, then MTLO
    bus.valid_i = 1'b1; bus.alucontrol_i = DIVU_C; bus.a_i = 32'd100; bus.b_i = 32'd7;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; bus.valid_i = 1'b0;
    @(negedge clk);
    check("rst_mid_hi", bus.hi_o, 32'd0);
    check("rst_mid_lo", bus.lo_o, 32'd0);
    check("rst_mid_busy", {31'd0, bus.busy_o}, 32'd0);
    @(posedge clk); #1;
    issue(MTLO_C, 32'h0000_ABCD, 32'd0);
    check("mtlo_lo", bus.lo_o, 32'h0000_ABCD);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
